// File: rtl/gsim_host_ctrl.sv
// Host-side controller for the GSIM solver.
// The host loads a 16-word B vector, then pulses start. The controller
// streams B into the solver, waits for the solver's result burst and
// captures it into a result buffer the host can read. It also flags
// timeouts and protocol errors.
//
// Handshake (solver side, no backpressure): gsim_in_en qualifies
// gsim_b_in one word per cycle. gsim_out_valid qualifies gsim_x_out one
// word per cycle. Each burst must be N back-to-back cycles, and any gap
// counts as a protocol error.
module gsim_host_ctrl #(
  parameter int N              = 16,
  parameter int B_W            = 16,
  parameter int X_W            = 32,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TMR_W          = 13
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           b_wr_en,
  input  logic [3:0]     b_wr_addr,
  input  logic [B_W-1:0] b_wr_data,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           err_timeout,
  output logic           err_proto,
  input  logic [3:0]     res_rd_addr,
  output logic [X_W-1:0] res_rd_data,
  output logic           gsim_in_en,
  output logic [B_W-1:0] gsim_b_in,
  input  logic           gsim_out_valid,
  input  logic [X_W-1:0] gsim_x_out
);

  localparam int CW = 4;
  localparam logic [CW-1:0]    LAST_IDX = CW'(N - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_RECV,
    S_DONE
  } state_t;

  // The FSM state is kept as a named, typed signal so it can be probed
  // hierarchically (dut.state).
  state_t           state;
  logic [B_W-1:0]   b_buf [N];
  logic [X_W-1:0]   r_buf [N];
  logic [CW-1:0]    send_cnt;
  logic [CW-1:0]    recv_cnt;
  logic             send_last;
  logic [TMR_W-1:0] timer;

  logic             start_ok;
  logic             b_wr_ok;
  logic             cap_en;
  logic [CW-1:0]    cap_idx;

  // A start is accepted only between runs. Host writes are accepted only
  // while no run is in flight.
  always_comb begin
    start_ok = start && ((state == S_IDLE) || (state == S_DONE));
    b_wr_ok  = b_wr_en && !busy;
  end

  // Decide whether this cycle captures a result word, and into which slot.
  always_comb begin
    cap_en  = 1'b0;
    cap_idx = recv_cnt;
    if (state == S_WAIT && gsim_out_valid) begin
      cap_en  = 1'b1;
      cap_idx = '0;
    end else if (state == S_RECV && gsim_out_valid) begin
      cap_en  = 1'b1;
    end
  end

  // B vector storage. It is host-writable only while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) b_buf[i] <= '0;
    end else if (b_wr_ok) begin
      b_buf[b_wr_addr] <= b_wr_data;
    end
  end

  // Result storage. It is written by the solver burst and never cleared by start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
    end else if (cap_en) begin
      r_buf[cap_idx] <= gsim_x_out;
    end
  end

  // Registered host read port with one cycle of latency, valid in any state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) res_rd_data <= '0;
    else        res_rd_data <= r_buf[res_rd_addr];
  end

  // Run sequencer: send B, wait for the burst, receive X, then report.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      send_cnt    <= '0;
      recv_cnt    <= '0;
      send_last   <= 1'b0;
      timer       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_proto   <= 1'b0;
      gsim_in_en  <= 1'b0;
      gsim_b_in   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            done        <= 1'b0;
            err_timeout <= 1'b0;
            err_proto   <= 1'b0;
            busy        <= 1'b1;
            gsim_in_en  <= 1'b1;
            // A same-cycle host write to slot 0 must reach the first word.
            if (b_wr_en && (b_wr_addr == 4'd0)) gsim_b_in <= b_wr_data;
            else                                gsim_b_in <= b_buf[0];
            send_cnt    <= CW'(1);
            send_last   <= 1'b0;
            state       <= S_SEND;
          end
        end

        S_SEND: begin
          if (gsim_out_valid) begin
            // The solver answered before it received the whole vector.
            err_proto  <= 1'b1;
            gsim_in_en <= 1'b0;
            gsim_b_in  <= '0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= S_DONE;
          end else if (send_last) begin
            // B[N-1] has been on the bus for its cycle, so end the burst.
            gsim_in_en <= 1'b0;
            gsim_b_in  <= '0;
            timer      <= '0;
            state      <= S_WAIT;
          end else begin
            gsim_b_in <= b_buf[send_cnt];
            // Stop counting at the last index rather than wrapping.
            if (send_cnt == LAST_IDX) send_last <= 1'b1;
            else                      send_cnt  <= send_cnt + CW'(1);
          end
        end

        S_WAIT: begin
          timer <= timer + TMR_W'(1);
          if (gsim_out_valid) begin
            // A first word arriving on the timeout cycle still wins.
            recv_cnt <= CW'(1);
            state    <= S_RECV;
          end else if (timer == TMO_LAST) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= S_DONE;
          end
        end

        S_RECV: begin
          if (gsim_out_valid) begin
            if (recv_cnt == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              recv_cnt <= recv_cnt + CW'(1);
            end
          end else begin
            // A gap in the burst means a short result. Keep what arrived.
            err_proto <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_host_ctrl.sv
// Bench for gsim_host_ctrl: directed runs against a simple solver model.
// The drivers push the expected B stream, run status and read data into
// queues. A negedge monitor pops and compares those values whenever the
// DUT presents them.
module tb_gsim_host_ctrl;

  localparam int N   = 16;
  localparam int TMO = 320;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        b_wr_en = 1'b0;
  logic [3:0]  b_wr_addr = '0;
  logic [15:0] b_wr_data = '0;
  logic        start = 1'b0;
  logic        busy, done, err_timeout, err_proto;
  logic [3:0]  res_rd_addr = '0;
  logic [31:0] res_rd_data;
  logic        gsim_in_en;
  logic [15:0] gsim_b_in;
  logic        gsim_out_valid = 1'b0;
  logic [31:0] gsim_x_out = '0;

  gsim_host_ctrl #(
    .N(N), .B_W(16), .X_W(32), .TIMEOUT_CYCLES(TMO), .TMR_W(13)
  ) dut (
    .clk(clk), .reset(reset),
    .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
    .start(start), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_proto(err_proto),
    .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data),
    .gsim_in_en(gsim_in_en), .gsim_b_in(gsim_b_in),
    .gsim_out_valid(gsim_out_valid), .gsim_x_out(gsim_x_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [15:0] exp_b_q[$];
  logic [31:0] exp_r_q[$];
  logic [1:0]  exp_st_q[$];
  logic [15:0] b_mdl [N];
  logic [31:0] r_mdl [N];
  int total = 0;
  int bad   = 0;
  logic rd_req = 1'b0;
  logic rd_v   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    total++;
    bad++;
    $display("FAIL %s: no expected entry or bound expired at %0t", name, $time);
  endtask

  always @(posedge clk) rd_v <= rd_req;

  // monitor
  int   run_len = 0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      run_len   = 0;
      done_prev = 1'b0;
    end else begin
      if (gsim_in_en) begin
        run_len++;
        if (exp_b_q.size() == 0) miss("b_in_extra");
        else check("b_in", {48'd0, gsim_b_in}, {48'd0, exp_b_q.pop_front()});
      end else if (run_len != 0) begin
        check("in_en_len", 64'(run_len), 64'(N));
        run_len = 0;
      end
      if (done && !done_prev) begin
        if (exp_st_q.size() == 0) miss("status_extra");
        else check("status{tmo,proto}", {62'd0, err_timeout, err_proto}, {62'd0, exp_st_q.pop_front()});
        check("busy_at_done", {63'd0, busy}, 64'd0);
      end
      done_prev = done;
      if (rd_v) begin
        if (exp_r_q.size() == 0) miss("rd_extra");
        else check("res_rd_data", {32'd0, res_rd_data}, {32'd0, exp_r_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic write_b(input logic [3:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    b_wr_en = 1'b1; b_wr_addr = a; b_wr_data = d;
    @(posedge clk); #1;
    b_wr_en = 1'b0;
    b_mdl[a] = d;
  endtask

  task automatic push_run(input logic [1:0] st);
    for (int i = 0; i < N; i++) exp_b_q.push_back(b_mdl[i]);
    exp_st_q.push_back(st);
  endtask

  task automatic start_run(input bit wr0, input logic [15:0] d0);
    @(posedge clk); #1;
    start = 1'b1;
    if (wr0) begin
      b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_data = d0;
    end
    @(posedge clk); #1;
    start = 1'b0; b_wr_en = 1'b0;
    check("in_en_after_start", {63'd0, gsim_in_en}, 64'd1);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("done_after_start", {63'd0, done}, 64'd0);
  endtask

  task automatic wait_in_en_low();
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!gsim_in_en) begin seen = 1; break; end
    end
    if (!seen) miss("wait_in_en_low");
  endtask

  // Solver model: wait `dly` WAIT cycles, then return n words base+i.
  task automatic gsim_reply(input int dly, input int n, input logic [31:0] base);
    wait_in_en_low();
    repeat (dly) begin @(posedge clk); #1; end
    for (int i = 0; i < n; i++) begin
      gsim_out_valid = 1'b1;
      gsim_x_out     = base + 32'(i);
      r_mdl[i]       = base + 32'(i);
      @(posedge clk); #1;
    end
    gsim_out_valid = 1'b0;
    gsim_x_out     = '0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    if (!seen) miss("wait_done");
  endtask

  task automatic read_res(input logic [3:0] a);
    @(posedge clk); #1;
    res_rd_addr = a; rd_req = 1'b1;
    exp_r_q.push_back(r_mdl[a]);
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
  endtask

  // main sequence
  initial begin
    int cnt;
    for (int i = 0; i < N; i++) begin b_mdl[i] = '0; r_mdl[i] = '0; end

    // Outputs while reset is held.
    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_errs", {62'd0, err_timeout, err_proto}, 64'd0);
    check("rst_in_en", {63'd0, gsim_in_en}, 64'd0);
    check("rst_b_in", {48'd0, gsim_b_in}, 64'd0);
    check("rst_rd_data", {32'd0, res_rd_data}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Run 1: B[i]=i+1, solver answers 300 cycles after the send.
    for (int i = 0; i < N; i++) write_b(4'(i), 16'(i + 1));
    push_run(2'b00);
    start_run(0, 16'd0);
    gsim_reply(300, N, 32'h0001_0000);
    wait_done();
    read_res(4'd5);
    read_res(4'd0);
    read_res(4'd15);
    // Extra out_valid while in DONE must be ignored.
    @(posedge clk); #1;
    gsim_out_valid = 1'b1; gsim_x_out = 32'hDEAD_BEEF;
    repeat (2) begin @(posedge clk); #1; end
    gsim_out_valid = 1'b0; gsim_x_out = '0;
    check("done_extra_ov_flags", {61'd0, done, err_timeout, err_proto}, 64'b100);
    read_res(4'd0);
    read_res(4'd1);

    // Run 2: no answer, so a timeout after exactly TMO WAIT cycles.
    push_run(2'b10);
    start_run(0, 16'd0);
    wait_in_en_low();
    cnt = 0;
    for (int i = 0; i < TMO + 50; i++) begin
      @(negedge clk);
      cnt++;
      if (done) break;
    end
    check("timeout_wait_cycles", 64'(cnt), 64'(TMO));
    read_res(4'd5);

    // Run 3: first word on the last WAIT cycle, so out_valid beats the timeout.
    push_run(2'b00);
    start_run(0, 16'd0);
    gsim_reply(TMO - 1, N, 32'h0002_0000);
    wait_done();
    read_res(4'd3);

    // Run 4: burst stops after 8 words, which is a protocol error.
    push_run(2'b01);
    start_run(0, 16'd0);
    for (int i = 8; i < N; i++) r_mdl[i] = 32'h0002_0000 + 32'(i);
    gsim_reply(4, 8, 32'h0003_0000);
    for (int i = 8; i < N; i++) r_mdl[i] = 32'h0002_0000 + 32'(i);
    wait_done();
    read_res(4'd7);
    read_res(4'd8);
    read_res(4'd15);

    // Run 5: start and a B write while busy are both ignored.
    push_run(2'b00);
    start_run(0, 16'd0);
    repeat (2) begin @(posedge clk); #1; end
    b_wr_en = 1'b1; b_wr_addr = 4'd3; b_wr_data = 16'hAAAA; start = 1'b1;
    @(posedge clk); #1;
    b_wr_en = 1'b0; start = 1'b0;
    gsim_reply(10, N, 32'h0004_0000);
    wait_done();

    // Run 6: a write to addr 0 in the start cycle is forwarded. B[3] keeps 4.
    b_mdl[0] = 16'h5555;
    push_run(2'b00);
    start_run(1, 16'h5555);
    gsim_reply(10, N, 32'h0006_0000);
    wait_done();
    read_res(4'd3);

    // Run 7: reset in the 5th SEND cycle aborts at once.
    push_run(2'b00);
    start_run(0, 16'd0);
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_in_en", {63'd0, gsim_in_en}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_b_in", {48'd0, gsim_b_in}, 64'd0);
    exp_b_q.delete();
    exp_st_q.delete();
    for (int i = 0; i < N; i++) begin b_mdl[i] = '0; r_mdl[i] = '0; end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    read_res(4'd0);
    read_res(4'd9);

    // Run 8: after reset the B buffer streams zeros.
    push_run(2'b00);
    start_run(0, 16'd0);
    gsim_reply(5, N, 32'h0005_0000);
    wait_done();
    read_res(4'd2);

    repeat (4) @(posedge clk);
    check("b_q_empty", 64'(exp_b_q.size()), 64'd0);
    check("st_q_empty", 64'(exp_st_q.size()), 64'd0);
    check("r_q_empty", 64'(exp_r_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
